// File: rtl/note_pkg.sv
// Shared definitions for the note player.
// - Pitch codes: REST (0), C4..B4 (1..12), C5/D5/E5 (13..15).
// - Playback FSM state encoding.
// - hp_of(): half-period, in clock cycles, of a pitch code at a given clock rate.
package note_pkg;

  localparam int unsigned HP_W = 17;

  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] C4   = 4'd1;
  localparam logic [3:0] CS4  = 4'd2;
  localparam logic [3:0] D4   = 4'd3;
  localparam logic [3:0] DS4  = 4'd4;
  localparam logic [3:0] E4   = 4'd5;
  localparam logic [3:0] F4   = 4'd6;
  localparam logic [3:0] FS4  = 4'd7;
  localparam logic [3:0] G4   = 4'd8;
  localparam logic [3:0] GS4  = 4'd9;
  localparam logic [3:0] A4   = 4'd10;
  localparam logic [3:0] AS4  = 4'd11;
  localparam logic [3:0] B4   = 4'd12;
  localparam logic [3:0] C5   = 4'd13;
  localparam logic [3:0] D5   = 4'd14;
  localparam logic [3:0] E5   = 4'd15;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLookup = 2'd1,
    StTone   = 2'd2,
    StGap    = 2'd3
  } state_t;

  // round(clk_hz / (2 * f)); frequencies held in milli-hertz so the rounding
  // stays exact in integer arithmetic. Only ever evaluated on constants.
  function automatic logic [HP_W-1:0] hp_of(input logic [3:0] code, input int unsigned clk_hz);
    logic [63:0] f_mhz;
    logic [63:0] hp;
    case (code)
      C4:      f_mhz = 64'd261626;
      CS4:     f_mhz = 64'd277183;
      D4:      f_mhz = 64'd293665;
      DS4:     f_mhz = 64'd311127;
      E4:      f_mhz = 64'd329628;
      F4:      f_mhz = 64'd349228;
      FS4:     f_mhz = 64'd369994;
      G4:      f_mhz = 64'd391995;
      GS4:     f_mhz = 64'd415305;
      A4:      f_mhz = 64'd440000;
      AS4:     f_mhz = 64'd466164;
      B4:      f_mhz = 64'd493883;
      C5:      f_mhz = 64'd523251;
      D5:      f_mhz = 64'd587330;
      E5:      f_mhz = 64'd659255;
      default: f_mhz = 64'd0;
    endcase
    if (f_mhz == 64'd0) begin
      hp = 64'd0;
    end else begin
      hp = (64'(clk_hz) * 64'd1000 + f_mhz) / (64'd2 * f_mhz);
    end
    hp_of = hp[HP_W-1:0];
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator.
// - clk, reset   : clock, asynchronous active-low reset
// - en           : advance the tone counter this cycle
// - half_period  : toggle spacing in cycles; 0 means silence
// - restart      : clear counter and wave (start of a new note)
// - wave         : square-wave output, period 2*half_period
module tone_gen
  import note_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [HP_W-1:0] half_period,
  input  logic            restart,
  output logic            wave
);

  logic [HP_W-1:0] r_cnt;
  logic            r_wave;
  logic            w_last;

  assign w_last = (r_cnt == half_period - HP_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (restart) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (en && (half_period != '0)) begin
      if (w_last) begin
        r_cnt  <= '0;
        r_wave <= ~r_wave;
      end else begin
        r_cnt  <= r_cnt + HP_W'(1);
      end
    end
  end

  assign wave = r_wave;

endmodule

// File: rtl/note_player.sv
// Note store and audio stage downstream of the playback controller.
// - clk, reset     : clock, asynchronous active-low reset
// - note_in        : pitch code to record
// - ld_note        : record strobe; falling edge writes note_in
// - ld_play        : playback enable
// - note_counter   : index of the note to play
// - audio_out      : square-wave audio
// - cur_note       : pitch code currently sounding
// - wr_count       : next write index (saturates at 15)
// - busy           : FSM not idle
module note_player
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned GAP_CYCLES = 1250000,
  parameter int unsigned DEPTH      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_in,
  input  logic       ld_note,
  input  logic       ld_play,
  input  logic [3:0] note_counter,
  output logic       audio_out,
  output logic [3:0] cur_note,
  output logic [3:0] wr_count,
  output logic       busy
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [3:0]       r_mem [DEPTH];
  logic             r_ld_note;
  logic [3:0]       r_wr_count;
  logic [3:0]       r_prev_cnt;
  logic [3:0]       r_cur_note;
  logic [HP_W-1:0]  r_hp;
  logic [GAP_W-1:0] r_gap_cnt;
  state_t           r_state;
  state_t           w_state_d;

  logic             w_wr;
  logic             w_chg;
  logic             w_gap_done;
  logic [3:0]       w_lookup_code;
  logic             w_wave;
  logic [HP_W-1:0]  w_hp_tab [16];

  // Half-period table folds to constants at elaboration.
  for (genvar g = 0; g < 16; g++) begin : g_hp
    assign w_hp_tab[g] = hp_of(4'(g), CLK_HZ);
  end

  assign w_wr          = r_ld_note & ~ld_note;
  assign w_chg         = ld_play & (note_counter != r_prev_cnt);
  assign w_gap_done    = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign w_lookup_code = r_mem[note_counter];

  // Recording path, independent of playback state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_ld_note  <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_ld_note <= ld_note;
      if (w_wr) begin
        r_mem[r_wr_count] <= note_in;
        if (r_wr_count != 4'(DEPTH - 1)) begin
          r_wr_count <= r_wr_count + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (ld_play) w_state_d = StLookup;
      StLookup: w_state_d = StTone;
      StTone:   if (w_chg) w_state_d = StGap;
      StGap:    if (w_gap_done) w_state_d = StLookup;
    endcase
    if (!ld_play) begin
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_prev_cnt <= '0;
      r_cur_note <= '0;
      r_hp       <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_prev_cnt <= note_counter;
      if (r_state == StLookup && ld_play) begin
        r_cur_note <= w_lookup_code;
        r_hp       <= w_hp_tab[w_lookup_code];
      end
      // Gap is armed only from TONE, so a change during GAP never restarts it.
      if (r_state == StTone && w_chg) begin
        r_gap_cnt <= '0;
      end else if (r_state == StGap) begin
        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      end
    end
  end

  tone_gen u_tone_gen (
    .clk         (clk),
    .reset       (reset),
    .en          (r_state == StTone),
    .half_period (r_hp),
    .restart     (r_state == StLookup),
    .wave        (w_wave)
  );

  // Wave is only heard while in TONE; every exit silences on the same edge.
  assign audio_out = w_wave & (r_state == StTone);
  assign cur_note  = r_cur_note;
  assign wr_count  = r_wr_count;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_note_player.sv
// Scoreboarded bench for note_player: audio edges are predicted from musical
// pitch (equal temperament around A4 = 440 Hz) and checked by a monitor.
module tb_note_player;

  localparam int unsigned CLK_HZ = 100000;
  localparam int unsigned GAP    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] note_in = '0;
  logic       ld_note = 1'b0;
  logic       ld_play = 1'b0;
  logic [3:0] note_counter = '0;
  logic       audio_out;
  logic [3:0] cur_note;
  logic [3:0] wr_count;
  logic       busy;

  note_player #(
    .CLK_HZ     (CLK_HZ),
    .GAP_CYCLES (GAP),
    .DEPTH      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .note_in      (note_in),
    .ld_note      (ld_note),
    .ld_play      (ld_play),
    .note_counter (note_counter),
    .audio_out    (audio_out),
    .cur_note     (cur_note),
    .wr_count     (wr_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int unsigned t;
    logic        lvl;
  } ev_t;
  ev_t sb[$];

  int mdl_mem[16];
  int mdl_wr = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Half period from the pitch itself: semitone distance from A4.
  function automatic int hp_model(input int code);
    int  semi;
    real f;
    if (code == 0) return 0;
    if (code <= 12) semi = code - 10;
    else if (code == 13) semi = 3;
    else if (code == 14) semi = 5;
    else semi = 7;
    f = 440.0 * (2.0 ** (real'(semi) / 12.0));
    return $rtoi($floor(real'(CLK_HZ) / (2.0 * f) + 0.5));
  endfunction

  // Monitor: every audio edge must match the head of the scoreboard.
  logic mon_en = 1'b0;
  logic mon_prev = 1'b0;
  ev_t  mon_e;
  always @(negedge clk) begin
    if (mon_en && (audio_out != mon_prev)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL audio_unexpected: edge to %0b at cycle %0d, none expected", audio_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("audio_time", int'(cyc), int'(mon_e.t));
        check("audio_level", int'(audio_out), int'(mon_e.lvl));
      end
      mon_prev = audio_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] v);
    note_in = v;
    ld_note = 1'b1;
    tick(1);
    ld_note = 1'b0;
    tick(1);
    mdl_mem[mdl_wr] = int'(v);
    if (mdl_wr < 15) mdl_wr++;
  endtask

  // Push the toggles of a tone entered at edge t0 that lie at or before tend.
  task automatic sched(input int code, input int unsigned t0, input int unsigned tend,
                       output logic lvl);
    int hp;
    ev_t e;
    hp = hp_model(code);
    lvl = 1'b0;
    if (hp != 0) begin
      for (int unsigned t = t0 + hp; t <= tend; t += hp) begin
        lvl = ~lvl;
        e.t = t;
        e.lvl = lvl;
        sb.push_back(e);
      end
    end
  endtask

  task automatic push_fall(input logic lvl, input int unsigned t);
    ev_t e;
    if (lvl) begin
      e.t = t;
      e.lvl = 1'b0;
      sb.push_back(e);
    end
  endtask

  // End cycle for a note: ntog toggles then part of a half period.
  function automatic int unsigned note_end(input int code, input int unsigned t0,
                                           input int ntog);
    int hp;
    hp = hp_model(code);
    if (hp == 0) return t0 + $urandom_range(20, 50);
    return t0 + ntog * hp + $urandom_range(1, hp - 1);
  endfunction

  initial begin
    int unsigned m, c, t0;
    int          cur, nxt, code, hp;
    logic        lvl;
    int          seq[8];

    for (int i = 0; i < 16; i++) mdl_mem[i] = 0;

    // Reset state
    #3 reset = 1'b0;
    tick(2);
    check("rst_audio", audio_out, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_cur_note", cur_note, 0);
    reset = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // Recording
    pulse(4'd10);
    pulse(4'd1);
    pulse(4'd0);
    check("wr_count_3", wr_count, 3);
    for (int i = 0; i < 14; i++) pulse(4'($urandom_range(0, 15)));
    check("wr_count_sat", wr_count, 15);

    // First note from idle
    cur = 0;
    note_counter = 4'd0;
    ld_play = 1'b1;
    m = cyc;
    t0 = m + 2;
    code = mdl_mem[0];
    c = note_end(code, t0, 4);
    sched(code, t0, c, lvl);
    tick(1);
    check("busy_after_1", busy, 1);
    tick(1);
    check("cur_note_first", cur_note, code);
    wait_until(c);

    // Note changes: fixed path 1, 2 (rest), 15, wrap to 0, then random
    seq[0] = 1; seq[1] = 2; seq[2] = 15; seq[3] = 0;
    for (int i = 4; i < 8; i++) seq[i] = -1;
    for (int i = 0; i < 8; i++) begin
      nxt = (seq[i] >= 0) ? seq[i] : (cur + $urandom_range(1, 15)) % 16;
      note_counter = 4'(nxt);
      push_fall(lvl, c + 1);
      t0 = c + 2 + GAP;
      tick(2);
      check("gap_busy", busy, 1);
      check("gap_silent", audio_out, 0);
      // Occasionally move again inside the gap: ignored, but LOOKUP sees it
      if (i >= 4 && $urandom_range(0, 1) == 1) begin
        nxt = (nxt + $urandom_range(1, 15)) % 16;
        note_counter = 4'(nxt);
      end
      cur = nxt;
      code = mdl_mem[cur];
      wait_until(t0);
      check("cur_note_lookup", cur_note, code);
      c = note_end(code, t0, $urandom_range(1, 3));
      sched(code, t0, c, lvl);
      if (code == 0) begin
        tick(5);
        check("rest_busy", busy, 1);
      end
      wait_until(c);
    end

    // Leave playback mid-tone while the wave is high
    nxt = (cur == 0) ? 1 : 0;
    note_counter = 4'(nxt);
    push_fall(lvl, c + 1);
    t0 = c + 2 + GAP;
    cur = nxt;
    code = mdl_mem[cur];
    hp = hp_model(code);
    c = t0 + hp + hp / 2;
    sched(code, t0, c, lvl);
    wait_until(c);
    ld_play = 1'b0;
    push_fall(lvl, c + 1);
    tick(1);
    check("stop_busy", busy, 0);
    check("stop_audio", audio_out, 0);
    check("stop_cur_note", cur_note, code);
    tick(3);

    // Reset mid-tone
    ld_play = 1'b1;
    m = cyc;
    t0 = m + 2;
    c = t0 + hp + hp / 2;
    sched(code, t0, c, lvl);
    wait_until(c);
    #2 reset = 1'b0;
    push_fall(lvl, c + 1);
    #1;
    check("midrst_audio", audio_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_wr_count", wr_count, 0);
    check("midrst_cur_note", cur_note, 0);
    tick(1);
    ld_play = 1'b0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 0;
    mdl_wr = 0;
    tick(1);
    reset = 1'b1;
    tick(1);

    // Memory reads back cleared; then a fresh write lands in entry 0
    for (int k = 15; k >= 14; k--) begin
      note_counter = 4'(k);
      ld_play = 1'b1;
      tick(3);
      check("clr_busy", busy, 1);
      check("clr_mem", cur_note, 0);
      ld_play = 1'b0;
      tick(2);
    end
    pulse(4'd5);
    check("wr_after_rst", wr_count, 1);
    note_counter = 4'd0;
    ld_play = 1'b1;
    tick(3);
    check("mem0_new", cur_note, 5);
    ld_play = 1'b0;
    tick(5);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
